// File: rtl/fft_peak_detect.sv
// fft_peak_detect: streaming peak and energy detector for FFT output frames.
// Squares each bin (stage 1), sums to |X|^2 (stage 2), tracks the running
// peak and energy per frame (stage 3), then registers the frame result.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   in_valid      - din_r/din_i carry one FFT bin this cycle
//   din_r, din_i  - signed real/imag bin components, natural bin order
//   frame_clr     - abort the partial frame and restart at bin 0
//   out_valid     - one-cycle pulse with a completed frame result
//   peak_idx      - bin index of the largest |X|^2 (lowest index on ties)
//   peak_mag      - |X|^2 of the peak bin
//   frame_energy  - sum of |X|^2 over the frame
//   busy          - frame partially accepted or data still in flight
module fft_peak_detect #(
   parameter int unsigned N_PT  = 32,
   parameter int unsigned DIN_W = 16,
   localparam int unsigned IDX_W = $clog2(N_PT),
   localparam int unsigned MAG_W = 2 * DIN_W,
   localparam int unsigned ENG_W = 2 * DIN_W + $clog2(N_PT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [DIN_W-1:0] din_r,
   input  logic signed [DIN_W-1:0] din_i,
   input  logic                    frame_clr,
   output logic                    out_valid,
   output logic        [IDX_W-1:0] peak_idx,
   output logic        [MAG_W-1:0] peak_mag,
   output logic        [ENG_W-1:0] frame_energy,
   output logic                    busy
);

   localparam int unsigned SQ_W   = 2 * DIN_W - 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PT - 1);

   // Squares are computed at full product width; the true square of a
   // DIN_W-bit signed value always fits in SQ_W unsigned bits.
   logic signed [MAG_W-1:0] ext_r_c, ext_i_c, prod_r_c, prod_i_c;

   assign ext_r_c  = MAG_W'(din_r);
   assign ext_i_c  = MAG_W'(din_i);
   assign prod_r_c = ext_r_c * ext_r_c;
   assign prod_i_c = ext_i_c * ext_i_c;

   logic             s1_valid, s2_valid, done;
   logic [SQ_W-1:0]  s1_sq_r, s1_sq_i;
   logic [MAG_W-1:0] s2_mag;
   logic [IDX_W-1:0] cnt, run_idx;
   logic [MAG_W-1:0] run_mag;
   logic [ENG_W-1:0] acc;

   // Pipeline, running peak/energy and held frame result.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid     <= 1'b0;
         s1_sq_r      <= '0;
         s1_sq_i      <= '0;
         s2_valid     <= 1'b0;
         s2_mag       <= '0;
         done         <= 1'b0;
         cnt          <= '0;
         run_idx      <= '0;
         run_mag      <= '0;
         acc          <= '0;
         out_valid    <= 1'b0;
         peak_idx     <= '0;
         peak_mag     <= '0;
         frame_energy <= '0;
      end else begin
         out_valid <= 1'b0;
         if (frame_clr) begin
            // Drop everything in flight; the held result stays untouched.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            run_idx  <= '0;
            run_mag  <= '0;
            acc      <= '0;
         end else begin
            s1_valid <= in_valid;
            s1_sq_r  <= SQ_W'(prod_r_c);
            s1_sq_i  <= SQ_W'(prod_i_c);

            s2_valid <= s1_valid;
            s2_mag   <= MAG_W'(s1_sq_r) + MAG_W'(s1_sq_i);

            done <= 1'b0;
            if (s2_valid) begin
               cnt <= cnt + IDX_W'(1);
               acc <= (cnt == '0) ? ENG_W'(s2_mag) : acc + ENG_W'(s2_mag);
               // Bin 0 loads unconditionally; strict compare keeps lower index on ties.
               if ((cnt == '0) || (s2_mag > run_mag)) begin
                  run_mag <= s2_mag;
                  run_idx <= cnt;
               end
               if (cnt == LAST) done <= 1'b1;
            end

            // Running regs already include the last bin; a new frame's bin 0
            // may overwrite them on this same edge without affecting the copy.
            if (done) begin
               out_valid    <= 1'b1;
               peak_idx     <= run_idx;
               peak_mag     <= run_mag;
               frame_energy <= acc;
            end
         end
      end
   end

   assign busy = (cnt != '0) | s1_valid | s2_valid | done;

endmodule
